aes_key_expand: RTL and testbench

Iterative AES-128 key schedule. Given a 128-bit cipher key, it computes the eleven round keys (round 0 to round 10), one round per clock, and stores them in an internal register bank. The bank is read through a registered port that supplies `inputkey` to the AddRoundKey stage directly downstream. The round controller selects which key is presented for each round.

---
 rtl/aes_key_expand.sv | 140 ++++++++++++++
 tb/tb_aes_key_expand.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule with registered round-key read port
// Computes one round key per clock into an 11-entry bank.
module aes_key_expand (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         success
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  // Row r holds S-box entries 16r..16r+15; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] hi;
    hi = 11'd2047 - {x, 3'b000};
    return SBOX[hi -: 8];
  endfunction

  state_t       state_q, state_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         success_q, success_d;
  logic [127:0] round_key_q, round_key_d;

  logic [127:0] prev;
  logic [31:0]  rot, t, w0, w1, w2, w3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;

  always_comb begin
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      if (cnt_q == 4'(i + 1)) prev = rk_q[i];
    end

    rot = {prev[23:0], prev[31:24]};
    t   = {sbox(rot[31:24]) ^ rcon_q, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w0  = prev[127:96] ^ t;
    w1  = prev[95:64]  ^ w0;
    w2  = prev[63:32]  ^ w1;
    w3  = prev[31:0]   ^ w2;
    next_key  = {w0, w1, w2, w3};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    state_d   = state_q;
    cnt_d     = cnt_q;
    rcon_d    = rcon_q;
    busy_d    = busy_q;
    success_d = success_q;
    for (int i = 0; i < 11; i++) rk_d[i] = rk_q[i];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rk_d[0]   = cipher_key;
          cnt_d     = 4'd1;
          rcon_d    = 8'h01;
          busy_d    = 1'b1;
          success_d = 1'b0;
          state_d   = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int i = 1; i < 11; i++) begin
          if (cnt_q == 4'(i)) rk_d[i] = next_key;
        end
        // The last round parks cnt/rcon so the bank index never leaves 0..10.
        if (cnt_q == 4'd10) begin
          busy_d    = 1'b0;
          success_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          rcon_d = rcon_next;
        end
      end
      default: state_d = S_IDLE;
    endcase

    round_key_d = '0;
    for (int i = 0; i < 11; i++) begin
      if (round_sel == 4'(i)) round_key_d = rk_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rcon_q      <= '0;
      busy_q      <= 1'b0;
      success_q   <= 1'b0;
      round_key_q <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      success_q   <= success_d;
      round_key_q <= round_key_d;
      for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign round_key = round_key_q;
  assign busy      = busy_q;
  assign success   = success_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed-vector bench for aes_key_expand
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher_key = '0;
  logic [3:0]   round_sel = '0;
  logic [127:0] round_key;
  logic         busy;
  logic         success;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R4  = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K3     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expand dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cipher_key (cipher_key),
    .round_sel  (round_sel),
    .round_key  (round_key),
    .busy       (busy),
    .success    (success)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic read_key(input logic [3:0] sel, input logic [127:0] exp, input string tag);
    round_sel = sel;
    tick();
    chk(tag, round_key, exp);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_success", success, 0);
    chk("rst_round_key", round_key, 0);

    // FIPS-197 A.1 with a second start injected mid-expansion
    cipher_key = K1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_success", success, 0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) round_sel = 4'd4;
      if (i == 4) begin
        start = 1'b1;
        cipher_key = K2;
      end
      tick();
      start = 1'b0;
      if (i == 3) chk("early_rk4", round_key, 0);
      if (i == 5) chk("rk4_after_e4", round_key, K1_R4);
      if (i < 10) begin
        chk($sformatf("busy_e%0d", i), busy, 1);
        chk($sformatf("success_e%0d", i), success, 0);
      end else begin
        chk("busy_e10", busy, 0);
        chk("success_e10", success, 1);
      end
    end
    read_key(4'd0, K1, "a1_rk0");
    read_key(4'd1, K1_R1, "a1_rk1");
    read_key(4'd2, K1_R2, "a1_rk2");
    read_key(4'd4, K1_R4, "a1_rk4");
    read_key(4'd10, K1_R10, "a1_rk10");
    read_key(4'd11, 128'h0, "oor_11");
    read_key(4'd12, 128'h0, "oor_12");
    read_key(4'd15, 128'h0, "oor_15");
    chk("done_hold_success", success, 1);

    // back-to-back re-key from DONE
    cipher_key = K3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rekey_success_drop", success, 0);
    chk("rekey_busy", busy, 1);
    repeat (9) tick();
    chk("rekey_e9_success", success, 0);
    tick();
    chk("rekey_e10_success", success, 1);
    read_key(4'd0, K3, "c1_rk0");
    read_key(4'd10, K3_R10, "c1_rk10");

    // reset in the middle of an expansion
    cipher_key = K1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_success", success, 0);
    for (int s = 0; s < 16; s++) begin
      read_key(4'(s), 128'h0, $sformatf("midrst_rk%0d", s));
    end
    chk("midrst_success_hold", success, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("fresh_success", success, 1);
    read_key(4'd1, K1_R1, "fresh_rk1");
    read_key(4'd10, K1_R10, "fresh_rk10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
